// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multi-cycle RV32I main controller:
//   - FSM state encoding (also exported on the debug 'state' port)
//   - pc_src / wb_sel mux encodings
//   - RV32I major opcode constants
//   - ctrl_word_t, the bundle of per-step datapath selects and enables
//   - is_legal_opcode(), the set of opcodes this core executes
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_ALU   = 2'd1;
    localparam logic [1:0] PC_SRC_INIT  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU   = 2'd0;
    localparam logic [1:0] WB_SEL_MEM   = 2'd1;
    localparam logic [1:0] WB_SEL_PC4   = 2'd2;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       imm_we;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       retire;
    } ctrl_word_t;

    // Anything outside this list is trapped in DECODE.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
            OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_R_TYPE,
            OPCODE_FENCE: is_legal_opcode = 1'b1;
            default:      is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the controller and the shared-memory datapath.
//   master : the controller (drives selects/enables, reads memory/ALU status)
//   slave  : the datapath / memory side
// Datapath -> controller: instr_in, mem_ready, branch_taken
// Controller -> datapath: mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
//   imm_we, alu_src_a, alu_src_b, rf_we, wb_sel, retire, instret, trap,
//   state, pc_init
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [31:0] instr_in;
    logic        mem_ready;
    logic        branch_taken;

    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        imm_we;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic [31:0] instret;
    logic        trap;
    logic [2:0]  state;
    logic [31:0] pc_init;

    modport master (
        input  instr_in, mem_ready, branch_taken,
        output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, imm_we,
               alu_src_a, alu_src_b, rf_we, wb_sel, retire, instret, trap,
               state, pc_init
    );

    modport slave (
        output instr_in, mem_ready, branch_taken,
        input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, imm_we,
               alu_src_a, alu_src_b, rf_we, wb_sel, retire, instret, trap,
               state, pc_init
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_decode
// Purely combinational map from (state, latched opcode, branch_taken,
// mem_ready) to the control word for the current step.
//   state        in  current FSM state
//   opcode       in  opcode latched at fetch
//   branch_taken in  ALU comparison result (meaningful in EXEC)
//   mem_ready    in  memory completes the outstanding request
//   ctrl         out control word for this cycle
// ---------------------------------------------------------------------------
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    // Everything defaults to idle; each state only raises what it needs.
    // TRAP deliberately falls through to the all-zero default.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_we  = 1'b1;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_src = PC_SRC_PLUS4;
                end
            end
            ST_DECODE: ctrl.imm_we = 1'b1;
            ST_EXEC: begin
                case (opcode)
                    OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_LUI:
                        ctrl.alu_src_b = 1'b1;
                    OPCODE_JALR: begin
                        ctrl.alu_src_b = 1'b1;
                        ctrl.pc_we     = 1'b1;
                        ctrl.pc_src    = PC_SRC_ALU;
                    end
                    OPCODE_AUIPC: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 1'b1;
                    end
                    OPCODE_JAL: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 1'b1;
                        ctrl.pc_we     = 1'b1;
                        ctrl.pc_src    = PC_SRC_ALU;
                    end
                    OPCODE_BRANCH: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 1'b1;
                        ctrl.pc_we     = branch_taken;
                        ctrl.pc_src    = PC_SRC_ALU;
                        ctrl.retire    = 1'b1;
                    end
                    OPCODE_FENCE: ctrl.retire = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                ctrl.mem_req  = 1'b1;
                ctrl.addr_sel = 1'b1;
                ctrl.mem_we   = (opcode == OPCODE_STORE);
                ctrl.retire   = (opcode == OPCODE_STORE) && mem_ready;
            end
            ST_WB: begin
                ctrl.rf_we  = 1'b1;
                ctrl.retire = 1'b1;
                if (opcode == OPCODE_LOAD)
                    ctrl.wb_sel = WB_SEL_MEM;
                else if (opcode == OPCODE_JAL || opcode == OPCODE_JALR)
                    ctrl.wb_sel = WB_SEL_PC4;
                else
                    ctrl.wb_sel = WB_SEL_ALU;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multi-cycle RV32I core (single shared memory port).
// Sequences FETCH/DECODE/EXEC/MEM/WB, traps on illegal opcodes or memory
// timeouts, and counts retired instructions.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  master side of multicycle_ctrl_if (see interface header)
// Parameters:
//   RESET_PC     value presented on pc_init (PC loads it during reset)
//   MEM_TIMEOUT  wait cycles allowed for mem_ready before trapping, 0 = off
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_if.master     bus
);

    state_t      state_q;
    logic [6:0]  opcode_q;
    logic [31:0] instret_q;
    logic [31:0] timeout_cnt;
    ctrl_word_t  ctrl;
    ctrl_word_t  out_w;
    logic        waiting;
    logic        timed_out;
    logic        unused_instr_bits;

    multicycle_ctrl_decode u_decode (
        .state        (state_q),
        .opcode       (opcode_q),
        .branch_taken (bus.branch_taken),
        .mem_ready    (bus.mem_ready),
        .ctrl         (ctrl)
    );

    // Only the opcode field is needed here; the rest of the word goes to IR.
    assign unused_instr_bits = ^bus.instr_in[31:7];

    assign waiting   = ctrl.mem_req && !bus.mem_ready;
    assign timed_out = (MEM_TIMEOUT != 0) && waiting &&
                       ((timeout_cnt + 32'd1) == MEM_TIMEOUT);

    // The FSM, opcode latch, timeout counter and retire counter share one
    // register block. The timeout counter is cleared whenever we enter a
    // state that issues a memory request, so every request gets the full
    // budget; a timeout drops the request by parking in TRAP until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            opcode_q    <= '0;
            instret_q   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (ctrl.retire)
                instret_q <= instret_q + 32'd1;
            if (waiting)
                timeout_cnt <= timeout_cnt + 32'd1;
            case (state_q)
                ST_FETCH: begin
                    if (timed_out) begin
                        state_q <= ST_TRAP;
                    end else if (bus.mem_ready) begin
                        opcode_q <= bus.instr_in[6:0];
                        state_q  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q <= is_legal_opcode(opcode_q) ? ST_EXEC : ST_TRAP;
                end
                ST_EXEC: begin
                    case (opcode_q)
                        OPCODE_LOAD, OPCODE_STORE: begin
                            state_q     <= ST_MEM;
                            timeout_cnt <= '0;
                        end
                        OPCODE_BRANCH, OPCODE_FENCE: begin
                            state_q     <= ST_FETCH;
                            timeout_cnt <= '0;
                        end
                        default: state_q <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (timed_out) begin
                        state_q <= ST_TRAP;
                    end else if (bus.mem_ready) begin
                        timeout_cnt <= '0;
                        state_q     <= (opcode_q == OPCODE_STORE) ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB: begin
                    state_q     <= ST_FETCH;
                    timeout_cnt <= '0;
                end
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // While reset is held every enable is forced low and the PC mux selects
    // pc_init, so an access cut off by reset is never half-completed.
    always_comb begin
        out_w = ctrl;
        if (rst) begin
            out_w        = '0;
            out_w.pc_src = PC_SRC_INIT;
        end
    end

    assign bus.mem_req   = out_w.mem_req;
    assign bus.mem_we    = out_w.mem_we;
    assign bus.addr_sel  = out_w.addr_sel;
    assign bus.ir_we     = out_w.ir_we;
    assign bus.pc_we     = out_w.pc_we;
    assign bus.pc_src    = out_w.pc_src;
    assign bus.imm_we    = out_w.imm_we;
    assign bus.alu_src_a = out_w.alu_src_a;
    assign bus.alu_src_b = out_w.alu_src_b;
    assign bus.rf_we     = out_w.rf_we;
    assign bus.wb_sel    = out_w.wb_sel;
    assign bus.retire    = out_w.retire;
    assign bus.instret   = instret_q;
    assign bus.trap      = (state_q == ST_TRAP);
    assign bus.state     = state_q;
    assign bus.pc_init   = RESET_PC;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed self-checking bench for multicycle_ctrl. A second instance with a
// short memory timeout exercises the timeout trap.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic rst_to;
    int   check_count;
    int   error_count;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus_to ();

    multicycle_ctrl #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(255)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multicycle_ctrl #(.RESET_PC(32'h0000_0100), .MEM_TIMEOUT(4)) u_dut_to (
        .clk (clk),
        .rst (rst_to),
        .bus (bus_to)
    );

    // 10 ns clock; inputs change and outputs are sampled around the negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Move to the next negedge, drive the inputs, then let outputs settle.
    task automatic applyStimulus(input logic ready, input logic [6:0] opcode,
                                 input logic taken);
        @(negedge clk);
        bus.mem_ready    = ready;
        bus.instr_in     = {25'd0, opcode};
        bus.branch_taken = taken;
        #1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst    = 1'b1;
        rst_to = 1'b1;
        bus.mem_ready       = 1'b0;
        bus.instr_in        = 32'd0;
        bus.branch_taken    = 1'b0;
        bus_to.mem_ready    = 1'b0;
        bus_to.instr_in     = 32'd0;
        bus_to.branch_taken = 1'b0;

        // Reset state
        #3;
        checkOutput("rst state",   32'(bus.state),   32'd0);
        checkOutput("rst mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst ir_we",   32'(bus.ir_we),   32'd0);
        checkOutput("rst pc_src",  32'(bus.pc_src),  32'd2);
        checkOutput("rst instret", bus.instret,      32'd0);
        checkOutput("rst trap",    32'(bus.trap),    32'd0);
        checkOutput("rst pc_init", bus_to.pc_init,   32'h0000_0100);
        @(negedge clk);
        rst = 1'b0;

        // OP-IMM with memory always ready: 0,1,2,4,0
        applyStimulus(1'b1, OPCODE_OP_IMM, 1'b0);
        checkOutput("opimm F state",  32'(bus.state),  32'd0);
        checkOutput("opimm F ir_we",  32'(bus.ir_we),  32'd1);
        checkOutput("opimm F pc_we",  32'(bus.pc_we),  32'd1);
        checkOutput("opimm F pc_src", 32'(bus.pc_src), 32'd0);
        checkOutput("opimm F rf_we",  32'(bus.rf_we),  32'd0);
        applyStimulus(1'b1, 7'd0, 1'b0);
        checkOutput("opimm D state",  32'(bus.state),   32'd1);
        checkOutput("opimm D imm_we", 32'(bus.imm_we),  32'd1);
        checkOutput("opimm D mem_req",32'(bus.mem_req), 32'd0);
        applyStimulus(1'b1, 7'd0, 1'b0);
        checkOutput("opimm E state",  32'(bus.state),     32'd2);
        checkOutput("opimm E a",      32'(bus.alu_src_a), 32'd0);
        checkOutput("opimm E b",      32'(bus.alu_src_b), 32'd1);
        checkOutput("opimm E rf_we",  32'(bus.rf_we),     32'd0);
        checkOutput("opimm E retire", 32'(bus.retire),    32'd0);
        applyStimulus(1'b1, 7'd0, 1'b0);
        checkOutput("opimm W state",  32'(bus.state),  32'd4);
        checkOutput("opimm W rf_we",  32'(bus.rf_we),  32'd1);
        checkOutput("opimm W retire", 32'(bus.retire), 32'd1);
        checkOutput("opimm W wb_sel", 32'(bus.wb_sel), 32'd0);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("opimm end state",   32'(bus.state),  32'd0);
        checkOutput("opimm end retire",  32'(bus.retire), 32'd0);
        checkOutput("opimm end instret", bus.instret,     32'd1);

        // LOAD with three wait cycles in MEM: 8 cycles in total
        applyStimulus(1'b1, OPCODE_LOAD, 1'b0);
        checkOutput("load F state", 32'(bus.state), 32'd0);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("load D state", 32'(bus.state), 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("load E state", 32'(bus.state),     32'd2);
        checkOutput("load E b",     32'(bus.alu_src_b), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 7'd0, 1'b0);
            checkOutput("load M wait state",    32'(bus.state),    32'd3);
            checkOutput("load M wait mem_req",  32'(bus.mem_req),  32'd1);
            checkOutput("load M wait addr_sel", 32'(bus.addr_sel), 32'd1);
            checkOutput("load M wait mem_we",   32'(bus.mem_we),   32'd0);
        end
        applyStimulus(1'b1, 7'd0, 1'b0);
        checkOutput("load M done state",  32'(bus.state),  32'd3);
        checkOutput("load M done retire", 32'(bus.retire), 32'd0);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("load W state",  32'(bus.state),  32'd4);
        checkOutput("load W wb_sel", 32'(bus.wb_sel), 32'd1);
        checkOutput("load W rf_we",  32'(bus.rf_we),  32'd1);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("load end state",   32'(bus.state), 32'd0);
        checkOutput("load end instret", bus.instret,    32'd2);

        // BRANCH taken, then not taken, 3 cycles each
        applyStimulus(1'b1, OPCODE_BRANCH, 1'b0);
        checkOutput("br1 F state", 32'(bus.state), 32'd0);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("br1 D state", 32'(bus.state), 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b1);
        checkOutput("br1 E state",  32'(bus.state),     32'd2);
        checkOutput("br1 E pc_we",  32'(bus.pc_we),     32'd1);
        checkOutput("br1 E pc_src", 32'(bus.pc_src),    32'd1);
        checkOutput("br1 E a",      32'(bus.alu_src_a), 32'd1);
        checkOutput("br1 E retire", 32'(bus.retire),    32'd1);
        applyStimulus(1'b1, OPCODE_BRANCH, 1'b0);
        checkOutput("br2 F state",   32'(bus.state), 32'd0);
        checkOutput("br1 instret",   bus.instret,    32'd3);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("br2 D state", 32'(bus.state), 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("br2 E state",  32'(bus.state),  32'd2);
        checkOutput("br2 E pc_we",  32'(bus.pc_we),  32'd0);
        checkOutput("br2 E retire", 32'(bus.retire), 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("br2 end state",   32'(bus.state), 32'd0);
        checkOutput("br2 end instret", bus.instret,    32'd4);

        // instret wrap: preset to all ones, then retire one OP
        force u_dut.instret_q = 32'hFFFF_FFFF;
        applyStimulus(1'b1, OPCODE_R_TYPE, 1'b0);
        release u_dut.instret_q;
        checkOutput("wrap preset", bus.instret, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("op D state", 32'(bus.state), 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("op E b", 32'(bus.alu_src_b), 32'd0);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("op W retire", 32'(bus.retire), 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("wrap instret", bus.instret, 32'd0);

        // STORE aborted by an asynchronous reset in MEM
        applyStimulus(1'b1, OPCODE_STORE, 1'b0);
        applyStimulus(1'b0, 7'd0, 1'b0);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("store E b", 32'(bus.alu_src_b), 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("store M state",  32'(bus.state),  32'd3);
        checkOutput("store M mem_we", 32'(bus.mem_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("store rst mem_we",  32'(bus.mem_we),  32'd0);
        checkOutput("store rst mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("store rst state",   32'(bus.state),   32'd0);
        checkOutput("store rst pc_src",  32'(bus.pc_src),  32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("store after rst mem_we", 32'(bus.mem_we), 32'd0);

        // Illegal opcode traps and holds, ignoring mem_ready
        applyStimulus(1'b1, 7'b1111111, 1'b0);
        applyStimulus(1'b0, 7'd0, 1'b0);
        checkOutput("ill D state", 32'(bus.state), 32'd1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, OPCODE_OP_IMM, 1'b0);
            checkOutput("ill T state",   32'(bus.state),   32'd5);
            checkOutput("ill T mem_req", 32'(bus.mem_req), 32'd0);
        end
        checkOutput("ill trap",    32'(bus.trap),   32'd1);
        checkOutput("ill retire",  32'(bus.retire), 32'd0);
        checkOutput("ill instret", bus.instret,     32'd0);
        rst = 1'b1;
        #1;
        checkOutput("ill rst trap",  32'(bus.trap),  32'd0);
        checkOutput("ill rst state", 32'(bus.state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Timeout instance: mem_ready stuck low in FETCH, trap after 4 waits
        rst_to = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("to wait state",   32'(bus_to.state),   32'd0);
            checkOutput("to wait mem_req", 32'(bus_to.mem_req), 32'd1);
        end
        @(negedge clk);
        #1;
        checkOutput("to trap state",   32'(bus_to.state),   32'd5);
        checkOutput("to trap mem_req", 32'(bus_to.mem_req), 32'd0);
        checkOutput("to trap flag",    32'(bus_to.trap),    32'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
